// File: rtl/pipe2_core.sv
// pipe2_core: parametrised two-stage (Fetch / Execute-Writeback) integer core with a stalling
// data-memory handshake. Define PIPE2_MUL_EN to build the single-cycle MUL; otherwise MUL is illegal.
module pipe2_core #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned IMEM_AW  = 8,
  parameter int unsigned DMEM_AW  = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  input  logic [XLEN-1:0]    dmem_rdata,
  input  logic               dmem_ready,
  output logic [IMEM_AW-1:0] pc_o,
  output logic [31:0]        instr_o,
  output logic               retire_o,
  output logic               illegal_o
);

  localparam int unsigned RW = $clog2(NREGS);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnSll = 6'b000000;
  localparam logic [5:0] FnSrl = 6'b000010;
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnXor = 6'b100110;
  localparam logic [5:0] FnNor = 6'b100111;
  localparam logic [5:0] FnSlt = 6'b101010;
`ifdef PIPE2_MUL_EN
  localparam logic [5:0] FnMul = 6'b011000;
`endif

  // Fetch and Execute state
  logic [IMEM_AW-1:0] r_pc;
  logic [IMEM_AW-1:0] r_ex_pc;
  logic [31:0]        r_ex_instr;
  logic               r_ex_valid;
  logic [XLEN-1:0]    r_regs [NREGS];

  // Field extraction
  logic [5:0]         w_op;
  logic [5:0]         w_funct;
  logic [RW-1:0]      w_rs;
  logic [RW-1:0]      w_rt;
  logic [RW-1:0]      w_rd;
  logic [4:0]         w_shamt;
  logic [15:0]        w_imm;

  logic [XLEN-1:0]    w_rs_val;
  logic [XLEN-1:0]    w_rt_val;
  logic [XLEN-1:0]    w_imm_sext;
  logic [XLEN-1:0]    w_imm_zext;
  logic [IMEM_AW-1:0] w_br_target;

  // Decode results
  logic               w_legal;
  logic               w_wen;
  logic               w_mem;
  logic               w_store;
  logic               w_taken;
  logic [RW-1:0]      w_dst;
  logic [XLEN-1:0]    w_result;
  logic [IMEM_AW-1:0] w_target;

  logic               w_stall;
  logic               w_retire;
  logic               w_redirect;

  assign w_op    = r_ex_instr[31:26];
  assign w_rs    = r_ex_instr[21 +: RW];
  assign w_rt    = r_ex_instr[16 +: RW];
  assign w_rd    = r_ex_instr[11 +: RW];
  assign w_shamt = r_ex_instr[10:6];
  assign w_funct = r_ex_instr[5:0];
  assign w_imm   = r_ex_instr[15:0];

  assign w_rs_val    = (w_rs == '0) ? '0 : r_regs[w_rs];
  assign w_rt_val    = (w_rt == '0) ? '0 : r_regs[w_rt];
  assign w_imm_sext  = XLEN'($signed(w_imm));
  assign w_imm_zext  = XLEN'(w_imm);
  assign w_br_target = r_ex_pc + IMEM_AW'(1) + IMEM_AW'(w_imm_sext);

  always_comb begin
    w_legal  = 1'b0;
    w_wen    = 1'b0;
    w_mem    = 1'b0;
    w_store  = 1'b0;
    w_taken  = 1'b0;
    w_dst    = w_rt;
    w_result = '0;
    w_target = w_br_target;
    case (w_op)
      OpRtype: begin
        w_legal = 1'b1;
        w_wen   = 1'b1;
        w_dst   = w_rd;
        case (w_funct)
          FnAdd:   w_result = w_rs_val + w_rt_val;
          FnSub:   w_result = w_rs_val - w_rt_val;
          FnAnd:   w_result = w_rs_val & w_rt_val;
          FnOr:    w_result = w_rs_val | w_rt_val;
          FnXor:   w_result = w_rs_val ^ w_rt_val;
          FnNor:   w_result = ~(w_rs_val | w_rt_val);
          FnSlt:   w_result = ($signed(w_rs_val) < $signed(w_rt_val)) ? XLEN'(1) : '0;
          FnSll:   w_result = w_rt_val << w_shamt;
          FnSrl:   w_result = w_rt_val >> w_shamt;
`ifdef PIPE2_MUL_EN
          FnMul:   w_result = w_rs_val * w_rt_val;
`endif
          default: begin
            w_legal = 1'b0;
            w_wen   = 1'b0;
          end
        endcase
      end
      OpAddi: begin
        w_legal  = 1'b1;
        w_wen    = 1'b1;
        w_result = w_rs_val + w_imm_sext;
      end
      OpOri: begin
        w_legal  = 1'b1;
        w_wen    = 1'b1;
        w_result = w_rs_val | w_imm_zext;
      end
      OpLw: begin
        w_legal  = 1'b1;
        w_mem    = 1'b1;
        w_wen    = 1'b1;
        w_result = dmem_rdata;
      end
      OpSw: begin
        w_legal = 1'b1;
        w_mem   = 1'b1;
        w_store = 1'b1;
      end
      OpBeq: begin
        w_legal = 1'b1;
        w_taken = (w_rs_val == w_rt_val);
      end
      OpBne: begin
        w_legal = 1'b1;
        w_taken = (w_rs_val != w_rt_val);
      end
      OpJ: begin
        w_legal  = 1'b1;
        w_taken  = 1'b1;
        w_target = r_ex_instr[IMEM_AW-1:0];
      end
      default: ;
    endcase
  end

  // Memory ops hold both stages until the slave accepts; illegal ops never reach here
  assign dmem_req   = r_ex_valid & w_mem;
  assign dmem_we    = dmem_req & w_store;
  assign dmem_addr  = DMEM_AW'(w_rs_val + w_imm_sext);
  assign dmem_wdata = w_rt_val;

  assign w_stall    = dmem_req & ~dmem_ready;
  assign w_retire   = r_ex_valid & ~w_stall;
  assign w_redirect = r_ex_valid & w_taken;

  assign imem_addr = r_pc;
  assign pc_o      = r_ex_pc;
  assign instr_o   = r_ex_valid ? r_ex_instr : 32'd0;
  assign retire_o  = w_retire;
  assign illegal_o = r_ex_valid & ~w_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= IMEM_AW'(RESET_PC);
      r_ex_pc    <= '0;
      r_ex_instr <= '0;
      r_ex_valid <= 1'b0;
    end else if (!w_stall) begin
      r_ex_instr <= imem_rdata;
      r_ex_pc    <= r_pc;
      // A taken redirect squashes the word fetched alongside it
      if (w_redirect) begin
        r_pc       <= w_target;
        r_ex_valid <= 1'b0;
      end else begin
        r_pc       <= r_pc + IMEM_AW'(1);
        r_ex_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_retire && w_wen && (w_dst != '0)) begin
      r_regs[w_dst] <= w_result;
    end
  end

endmodule
